// File: rtl/spi_cfg_pkg.sv
// Shared definitions for SPI-attached configuration slaves.
// Contents: frame sequencer state type, command byte layout, default idle timeout.
package spi_cfg_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned CMD_RD_BIT      = 7;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        RD_REQ = 3'd2,
        RD_CAP = 3'd3,
        RD     = 3'd4
    } state_e;

endpackage

// File: rtl/frame_idle_timer.sv
// Counts consecutive idle clocks of an open frame and flags expiry.
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   clear_i   restart the idle count (activity seen or no frame open)
//   expire_o  high while the count sits at TIMEOUT-1
module frame_idle_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int unsigned      CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

    // Saturate at the terminal count so an expiry deferred by the owner stays visible.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (clear_i) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != LAST) begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idle_cnt_q <= '0;
            expire_o   <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            expire_o   <= (idle_cnt_d == LAST);
        end
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Decodes SPI frames (command byte + data/dummy bytes) into register
// write/read strobes with auto-incrementing address, and returns read data
// to the serializer. A frame closes after TIMEOUT idle clocks.
// Ports:
//   iclk, rst                  clock, synchronous active-high reset
//   byte_valid, byte_in        completed byte from the deserializer
//   reg_addr, reg_wdata        register bank address / write data
//   reg_wr_en, reg_rd_en       single-cycle register strobes
//   reg_rdata                  read data, valid one cycle after reg_rd_en
//   tx_byte, tx_valid          byte for the serializer and its load pulse
//   busy                       frame open
//   frame_err                  overrun or empty write frame
module spi_cmd_sequencer
    import spi_cfg_pkg::*;
#(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              iclk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [BYTE_W-1:0] reg_wdata,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    input  logic [BYTE_W-1:0] reg_rdata,
    output logic [BYTE_W-1:0] tx_byte,
    output logic              tx_valid,
    output logic              busy,
    output logic              frame_err
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                has_data_q, has_data_d;
    logic                expire;

    logic [ADDR_W-1:0]   reg_addr_d;
    logic [BYTE_W-1:0]   reg_wdata_d, tx_byte_d;
    logic                reg_wr_en_d, reg_rd_en_d, tx_valid_d, busy_d, frame_err_d;

    frame_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk_i    (iclk),
        .rst_i    (rst),
        .clear_i  (byte_valid || (state_q == IDLE)),
        .expire_o (expire)
    );

    // State register.
    always_ff @(posedge iclk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            has_data_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            has_data_q <= has_data_d;
        end
    end

    // Next state. An arriving byte always beats a coinciding timeout; the
    // read request/capture states ignore expiry until RD is reached.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (byte_valid) state_d = byte_in[CMD_RD_BIT] ? RD_REQ : WR;
            WR:      if (!byte_valid && expire) state_d = IDLE;
            RD_REQ:  state_d = RD_CAP;
            RD_CAP:  state_d = RD;
            RD: begin
                if (byte_valid)  state_d = RD_REQ;
                else if (expire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        ptr_d       = ptr_q;
        has_data_d  = has_data_q;
        reg_addr_d  = reg_addr;
        reg_wdata_d = reg_wdata;
        tx_byte_d   = tx_byte;
        reg_wr_en_d = 1'b0;
        reg_rd_en_d = 1'b0;
        tx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        busy_d      = (state_d != IDLE);

        unique case (state_q)
            IDLE: begin
                if (byte_valid) begin
                    ptr_d      = byte_in[ADDR_W-1:0];
                    has_data_d = 1'b0;
                end
            end
            WR: begin
                if (byte_valid) begin
                    reg_wr_en_d = 1'b1;
                    reg_addr_d  = ptr_q;
                    reg_wdata_d = byte_in;
                    ptr_d       = ptr_q + ADDR_W'(1);
                    has_data_d  = 1'b1;
                end else if (expire && !has_data_q) begin
                    frame_err_d = 1'b1;
                end
            end
            RD_REQ: begin
                if (byte_valid) frame_err_d = 1'b1;
            end
            RD_CAP: begin
                if (byte_valid) frame_err_d = 1'b1;
                tx_byte_d  = reg_rdata;
                tx_valid_d = 1'b1;
                ptr_d      = ptr_q + ADDR_W'(1);
            end
            default: ;
        endcase

        // The read strobe is registered, so it is raised on entry to RD_REQ.
        if (state_d == RD_REQ) begin
            reg_rd_en_d = 1'b1;
            reg_addr_d  = ptr_d;
        end
    end

    // Output registers.
    always_ff @(posedge iclk) begin
        if (rst) begin
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            tx_byte   <= '0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            reg_addr  <= reg_addr_d;
            reg_wdata <= reg_wdata_d;
            reg_wr_en <= reg_wr_en_d;
            reg_rd_en <= reg_rd_en_d;
            tx_byte   <= tx_byte_d;
            tx_valid  <= tx_valid_d;
            busy      <= busy_d;
            frame_err <= frame_err_d;
        end
    end

endmodule
